rtc_multi_alarm: RTL

RTC_MULTI_ALARM -- requirements
Module: rtc_multi_alarm

---
 rtl/rtc_multi_alarm.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_multi_alarm.sv
// Real-time clock with a packed sec/min/hr/day/yr time word, one-cycle adjust
// arithmetic and NUM_ALARMS sticky hr:min:sec compare channels.
module rtc_multi_alarm #(
    parameter int unsigned NUM_ALARMS    = 4,
    parameter int unsigned TICK_DIV      = 1,
    parameter int unsigned DAYS_PER_YEAR = 365
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rtc_on,
    input  logic [1:0]            operation,
    input  logic [2:0]            alarm_sel,
    input  logic [31:0]           w_data,
    output logic [31:0]           r_data,
    output logic [NUM_ALARMS-1:0] alarm,
    output logic                  alarm_any
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = 17;
    localparam int unsigned DW = 11;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] mins;
        logic [4:0] hrs;
        logic [8:0] day;
        logic [5:0] yr;
    } rtc_time_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ALARM = 2'b10,
        OP_ADJ   = 2'b11
    } op_e;

    // Clamp out-of-range fields; the year field uses its full 6-bit range.
    function automatic rtc_time_t sat_time(input logic [31:0] w);
        rtc_time_t t;
        t = rtc_time_t'(w);
        if (t.sec > 6'd59) t.sec = 6'd59;
        if (t.mins > 6'd59) t.mins = 6'd59;
        if (t.hrs > 5'd23) t.hrs = 5'd23;
        if (t.day > 9'(DAYS_PER_YEAR - 1)) t.day = 9'(DAYS_PER_YEAR - 1);
        return t;
    endfunction

    function automatic rtc_time_t inc_time(input rtc_time_t t);
        rtc_time_t r;
        r = t;
        if (t.sec != 6'd59) begin
            r.sec = t.sec + 6'd1;
        end else begin
            r.sec = '0;
            if (t.mins != 6'd59) begin
                r.mins = t.mins + 6'd1;
            end else begin
                r.mins = '0;
                if (t.hrs != 5'd23) begin
                    r.hrs = t.hrs + 5'd1;
                end else begin
                    r.hrs = '0;
                    if (t.day != 9'(DAYS_PER_YEAR - 1)) begin
                        r.day = t.day + 9'd1;
                    end else begin
                        r.day = '0;
                        r.yr  = t.yr + 6'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    // One mixed-radix digit: returns {carry_or_borrow, value} for modulus m.
    function automatic logic [DW:0] digit(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic cin, input logic add,
                                          input logic [DW-1:0] m);
        logic [DW-1:0] s;
        logic [DW:0]   res;
        if (add) begin
            s   = a + b + DW'(cin);
            res = (s >= m) ? {1'b1, s - m} : {1'b0, s};
        end else begin
            s   = a + m - b - DW'(cin);
            res = (s >= m) ? {1'b0, s - m} : {1'b1, s};
        end
        return res;
    endfunction

    function automatic rtc_time_t adjust_time(input rtc_time_t t, input rtc_time_t o,
                                              input logic add);
        logic [DW:0] s, m, h, d, y;
        rtc_time_t   r;
        s = digit(DW'(t.sec),  DW'(o.sec),  1'b0,  add, DW'(60));
        m = digit(DW'(t.mins), DW'(o.mins), s[DW], add, DW'(60));
        h = digit(DW'(t.hrs),  DW'(o.hrs),  m[DW], add, DW'(24));
        d = digit(DW'(t.day),  DW'(o.day),  h[DW], add, DW'(DAYS_PER_YEAR));
        y = digit(DW'(t.yr),   DW'(o.yr),   d[DW], add, DW'(64));
        r.sec  = 6'(s);
        r.mins = 6'(m);
        r.hrs  = 5'(h);
        r.day  = 9'(d);
        r.yr   = 6'(y);
        return r;
    endfunction

    rtc_time_t             tm_q, tm_n, tm_inc1, tm_inc2, tm_base, offset;
    logic [PW-1:0]         presc_q, presc_n;
    logic                  defer_q, defer_n;
    logic                  tick, upd;
    logic [31:0]           rdata_q, rdata_n;
    logic [NUM_ALARMS-1:0] alarm_q, alarm_n, en_q, prog_sel, hit;
    logic                  alarm_any_q;
    logic [CW-1:0]         cmp_q [NUM_ALARMS];
    op_e                   op;

    // Next-state: commands, tick/deferred-tick advance and alarm compare.
    always_comb begin
        op       = op_e'(operation);
        tick     = (presc_q == PW'(TICK_DIV - 1));
        presc_n  = tick ? '0 : presc_q + PW'(1);
        tm_inc1  = inc_time(tm_q);
        tm_inc2  = inc_time(tm_inc1);
        tm_base  = defer_q ? tm_inc1 : tm_q;
        offset   = sat_time({w_data[31:6], 6'd0});
        tm_n     = tm_q;
        defer_n  = 1'b0;
        upd      = 1'b0;
        rdata_n  = rdata_q;
        prog_sel = '0;
        hit      = '0;

        if (rtc_on && op == OP_WRITE) begin
            tm_n    = sat_time(w_data);
            presc_n = '0;
            upd     = 1'b1;
        end else if (rtc_on && op == OP_ADJ) begin
            // A pending deferred tick folds into this adjust; a new tick waits.
            tm_n    = adjust_time(tm_base, offset, w_data[5]);
            defer_n = tick;
            upd     = 1'b1;
        end else begin
            if (tick && defer_q) begin
                tm_n = tm_inc2;
                upd  = 1'b1;
            end else if (tick || defer_q) begin
                tm_n = tm_inc1;
                upd  = 1'b1;
            end
            if (rtc_on && op == OP_READ) rdata_n = tm_q;
            if (rtc_on && op == OP_ALARM) begin
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    prog_sel[i] = (alarm_sel == 3'(i));
                end
            end
        end

        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit[i] = upd && en_q[i] && ({tm_n.sec, tm_n.mins, tm_n.hrs} == cmp_q[i]);
        end
        alarm_n = (alarm_q & ~prog_sel) | hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tm_q        <= '0;
            presc_q     <= '0;
            defer_q     <= 1'b0;
            rdata_q     <= '0;
            alarm_q     <= '0;
            alarm_any_q <= 1'b0;
            en_q        <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                cmp_q[i] <= '0;
            end
        end else begin
            tm_q        <= tm_n;
            presc_q     <= presc_n;
            defer_q     <= defer_n;
            rdata_q     <= rdata_n;
            alarm_q     <= alarm_n;
            alarm_any_q <= |alarm_n;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (prog_sel[i]) begin
                    cmp_q[i] <= w_data[31:15];
                    en_q[i]  <= w_data[14];
                end
            end
        end
    end

    assign r_data    = rdata_q;
    assign alarm     = alarm_q;
    assign alarm_any = alarm_any_q;

endmodule
